fetch_sequencer: RTL

//  Drives the PC-select inputs of program_counter and fetches the instruction at its pc output.
//  - Issues one single-outstanding request to instruction memory (imem) and buffers the returned

---
 rtl/fetch_sequencer.sv | 62 ++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch driving program_counter, with redirect squash and a 1-entry decode buffer
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [1:0]  pcmux,
   output logic [31:0] immbj,
   output logic [31:0] jump,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redir_valid,
   input  logic [31:0] redir_target
);
   typedef enum logic [1:0] {RST, REQ, WAIT, DROP} state_t;
   state_t state;
   logic redir;
   always_comb begin
      redir = redir_valid && (state != RST);
      immbj = '0;
      imem_addr = pc;
      jump = (state == RST) ? RESET_PC : {redir_target[31:2], 2'b00};
      imem_req = (state == REQ) && !redir && (!inst_valid || inst_ready);
      pcmux = (state == RST) ? ((RESET_PC == '0) ? 2'b00 : 2'b01) :
              redir ? 2'b01 :
              ((state == WAIT) && imem_rvalid) ? 2'b11 : 2'b10;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RST;
         inst_valid <= 1'b0;
         inst <= '0;
         inst_pc <= '0;
      end else begin
         if ((inst_valid && inst_ready) || redir) inst_valid <= 1'b0;
         case (state)
            RST: state <= REQ;
            REQ: if (imem_req && imem_gnt) state <= WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  state <= REQ;
                  if (!redir) begin
                     inst <= imem_rdata;
                     inst_pc <= pc;
                     inst_valid <= 1'b1;
                  end
               end else if (redir) state <= DROP;
            end
            DROP: if (imem_rvalid) state <= REQ;
            default: state <= RST;
         endcase
      end
   end
endmodule
